button_conditioner: RTL and testbench

Converts raw, asynchronous, bouncing push-button inputs into clean single-cycle command pulses for the alarm clock's time-setting path. It sits directly upstream of the up/down mod-N counters: its pulses drive their `up`/`down` enables, one pulse per press. Optional per-button auto-repeat produces a pulse train while a button is held, so hours and minutes can be scrolled quickly.

---
 rtl/button_conditioner.sv | 137 +++++++++++++
 tb/tb_button_conditioner.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Purpose : debounce raw push-buttons and turn presses into single-cycle command pulses,
//           with optional auto-repeat per button.
// Latency : raw edge -> level/press pulse after DB_CYCLES+2 edges; pulse is one cycle wide.
// Backpressure: none; pulses are fire-and-forget and are not held for a consumer.
//
// Ports:
//   clk      system clock, all state on rising edge
//   reset    asynchronous active-high clear of all state
//   btn_raw  [NB] raw, bouncing, asynchronous button levels (active-high)
//   pulse    [NB] registered one-cycle press / repeat pulses
//   level    [NB] registered debounced button level
module button_conditioner #(
  parameter int              NB          = 4,
  parameter int              DB_CYCLES   = 1_000_000,
  parameter int              HOLD_CYCLES = 50_000_000,
  parameter int              RATE_CYCLES = 10_000_000,
  parameter logic [NB-1:0]   REPEAT_MASK = {NB{1'b0}}
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [NB-1:0] btn_raw,
  output logic [NB-1:0] pulse,
  output logic [NB-1:0] level
);

  localparam int DBW  = $clog2(DB_CYCLES);
  localparam int TMAX = (HOLD_CYCLES > RATE_CYCLES) ? HOLD_CYCLES : RATE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [TW-1:0]  HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]  RATE_LAST = TW'(RATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } state_t;

  // Two-flop synchronizer for all buttons.
  logic [NB-1:0] s1;
  logic [NB-1:0] s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_ch
    logic [DBW-1:0] db_cnt;
    logic           stable;
    logic           accept;
    logic           rise;
    logic           fall;
    state_t         state;
    logic [TW-1:0]  timer;
    logic           pulse_q;

    // A level change is accepted on the edge where the counter already shows
    // DB_CYCLES-1 differing cycles and the input still differs. The press pulse
    // is issued on that same edge so it lines up with level rising.
    assign accept = (s2[i] != stable) && (db_cnt == DB_LAST);
    assign rise   = accept && s2[i];
    assign fall   = accept && !s2[i];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stable <= 1'b0;
        db_cnt <= '0;
      end else if (s2[i] == stable) begin
        db_cnt <= '0;
      end else if (accept) begin
        stable <= s2[i];
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end

    // Release has priority over everything, so a release landing on a repeat
    // edge kills that repeat. Non-repeat channels stay in IDLE while held; a new
    // press needs a new debounced rise, which cannot occur before a release.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state   <= IDLE;
        timer   <= '0;
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        if (fall) begin
          state <= IDLE;
          timer <= '0;
        end else begin
          case (state)
            IDLE: begin
              if (rise) begin
                pulse_q <= 1'b1;
                timer   <= '0;
                if (REPEAT_MASK[i]) state <= HOLD;
              end
            end
            HOLD: begin
              if (timer == HOLD_LAST) begin
                pulse_q <= 1'b1;
                timer   <= '0;
                state   <= REPEAT;
              end else begin
                timer <= timer + 1'b1;
              end
            end
            REPEAT: begin
              if (timer == RATE_LAST) begin
                pulse_q <= 1'b1;
                timer   <= '0;
              end else begin
                timer <= timer + 1'b1;
              end
            end
            default: begin
              state <= IDLE;
              timer <= '0;
            end
          endcase
        end
      end
    end

    assign pulse[i] = pulse_q;
    assign level[i] = stable;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Purpose : self-checking bench for button_conditioner (NB=2, DB=4, HOLD=10, RATE=3, mask 01).
// Latency : expected pulse/level events are tagged with the rising-edge index they follow.
// Backpressure: none; the monitor checks every pulse and every level change it observes.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] btn_raw = 2'b00;
  logic [1:0] pulse;
  logic [1:0] level;

  button_conditioner #(
    .NB(2),
    .DB_CYCLES(4),
    .HOLD_CYCLES(10),
    .RATE_CYCLES(3),
    .REPEAT_MASK(2'b01)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .pulse(pulse),
    .level(level)
  );

  always #5 clk = ~clk;

  // Index of the most recent rising edge.
  int edge_n = 0;
  always @(posedge clk) edge_n++;

  typedef struct {
    int         e;
    logic [1:0] v;
  } exp_t;

  exp_t pulse_q[$];
  exp_t level_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] prev_level = 2'b00;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_pulse(input int e, input logic [1:0] v);
    exp_t x;
    x.e = e;
    x.v = v;
    pulse_q.push_back(x);
  endtask

  task automatic exp_level(input int e, input logic [1:0] v);
    exp_t x;
    x.e = e;
    x.v = v;
    level_q.push_back(x);
  endtask

  task automatic drive_for(input logic [1:0] v, input int n);
    btn_raw = v;
    repeat (n) @(negedge clk);
    btn_raw = 2'b00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: outputs only move on rising edges, so the falling edge is a safe
  // sampling point. Every nonzero pulse and every level change must match the
  // head of its queue in both edge index and value.
  always @(negedge clk) begin
    exp_t x;
    if (pulse !== 2'b00) begin
      n_cmp++;
      if (pulse_q.size() == 0) begin
        n_bad++;
        $display("FAIL pulse_unexpected: got %b after edge %0d, want none", pulse, edge_n);
      end else begin
        x = pulse_q.pop_front();
        if (x.e != edge_n || x.v !== pulse) begin
          n_bad++;
          $display("FAIL pulse_event: got %b after edge %0d, want %b after edge %0d",
                   pulse, edge_n, x.v, x.e);
        end
      end
    end
    if (level !== prev_level) begin
      n_cmp++;
      if (level_q.size() == 0) begin
        n_bad++;
        $display("FAIL level_unexpected: got %b after edge %0d, want none", level, edge_n);
      end else begin
        x = level_q.pop_front();
        if (x.e != edge_n || x.v !== level) begin
          n_bad++;
          $display("FAIL level_event: got %b after edge %0d, want %b after edge %0d",
                   level, edge_n, x.v, x.e);
        end
      end
      prev_level = level;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int r0;

    // Reset state.
    #12;
    check("reset_pulse", pulse, 2'b00);
    check("reset_level", level, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    idle(5);

    // Clean press on button 1 (no repeat): pulse and level rise after b+5,
    // release sampled at b+12 drops level after b+17.
    @(negedge clk);
    b = edge_n + 1;
    exp_pulse(b + 5, 2'b10);
    exp_level(b + 5, 2'b10);
    exp_level(b + 17, 2'b00);
    drive_for(2'b10, 12);
    idle(10);

    // Glitch of 3 cycles is shorter than the debounce window: nothing happens.
    @(negedge clk);
    drive_for(2'b01, 3);
    idle(8);

    // Bounce: toggle every cycle, then hold high; only the final rise counts.
    // Held 8 cycles so the release (level falls b+13) beats the first repeat (b+15).
    for (int i = 0; i < 10; i++) begin
      btn_raw = (i % 2 == 0) ? 2'b01 : 2'b00;
      @(negedge clk);
    end
    b = edge_n + 1;
    exp_pulse(b + 5, 2'b01);
    exp_level(b + 5, 2'b01);
    exp_level(b + 13, 2'b00);
    drive_for(2'b01, 8);
    idle(10);

    // Auto-repeat on button 0, held 30 cycles: press b+5, repeats b+15 then
    // every 3 edges. Release sampled at b+30 lands level low after b+35, so
    // the b+33 repeat still fires and none follow.
    @(negedge clk);
    b = edge_n + 1;
    exp_pulse(b + 5, 2'b01);
    for (int k = 15; k <= 33; k += 3) exp_pulse(b + k, 2'b01);
    exp_level(b + 5, 2'b01);
    exp_level(b + 35, 2'b00);
    drive_for(2'b01, 30);
    idle(10);

    // Same stimulus on button 1 (repeat disabled): press pulse only.
    @(negedge clk);
    b = edge_n + 1;
    exp_pulse(b + 5, 2'b10);
    exp_level(b + 5, 2'b10);
    exp_level(b + 35, 2'b00);
    drive_for(2'b10, 30);
    idle(10);

    // Held 31 cycles: release accepted at b+36, the edge the next repeat
    // would fire on, so that repeat is suppressed.
    @(negedge clk);
    b = edge_n + 1;
    exp_pulse(b + 5, 2'b01);
    for (int k = 15; k <= 33; k += 3) exp_pulse(b + k, 2'b01);
    exp_level(b + 5, 2'b01);
    exp_level(b + 36, 2'b00);
    drive_for(2'b01, 31);
    idle(10);

    // Simultaneous press: both pulses in the same cycle.
    @(negedge clk);
    b = edge_n + 1;
    exp_pulse(b + 5, 2'b11);
    exp_level(b + 5, 2'b11);
    exp_level(b + 13, 2'b00);
    drive_for(2'b11, 8);
    idle(10);

    // Reset in HOLD just after b+8 with the button still held.
    @(negedge clk);
    b = edge_n + 1;
    exp_pulse(b + 5, 2'b01);
    exp_level(b + 5, 2'b01);
    exp_level(b + 8, 2'b00);
    btn_raw = 2'b01;
    while (edge_n < b + 7) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_hold_pulse", pulse, 2'b00);
    check("rst_hold_level", level, 2'b00);
    idle(2);
    reset = 1'b0;
    // First edge after deassertion is r0; it samples the held button as a new press.
    r0 = edge_n + 1;
    exp_pulse(r0 + 5, 2'b01);
    exp_pulse(r0 + 15, 2'b01);
    exp_pulse(r0 + 18, 2'b01);
    exp_level(r0 + 5, 2'b01);
    exp_level(r0 + 19, 2'b00);
    idle(14);
    btn_raw = 2'b00;
    idle(10);

    // Reset asserted while a press pulse is on the output clears it at once.
    @(negedge clk);
    b = edge_n + 1;
    btn_raw = 2'b10;
    while (edge_n < b + 4) @(negedge clk);
    @(posedge clk);
    #1;
    check("mid_pulse_pulse", pulse, 2'b10);
    check("mid_pulse_level", level, 2'b10);
    reset = 1'b1;
    #1;
    check("rst_pulse_pulse", pulse, 2'b00);
    check("rst_pulse_level", level, 2'b00);
    btn_raw = 2'b00;
    idle(2);
    reset = 1'b0;
    idle(12);

    // Every expected event must have been observed.
    check("pulse_q_left", 2'(pulse_q.size() > 0 ? 1 : 0), 2'b00);
    check("level_q_left", 2'(level_q.size() > 0 ? 1 : 0), 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
